// File: rtl/div_ctrl_pkg.sv
// Shared constants and state encoding for the EX-stage divide controller.
package div_ctrl_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned RES_W           = 64;
    localparam int unsigned DIV_TIMEOUT_DEF = 48;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_ctrl.sv
// Sequences a multi-cycle divide for the EX stage: latches operands, stalls the
// front end, forwards the result to HI/LO and aborts on flush or timeout.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              div_valid_i,
    input  logic              div_signed_i,
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    input  logic              flush_i,
    output logic              div_start_o,
    output logic              div_signed_o,
    output logic [DATA_W-1:0] div_op1_o,
    output logic [DATA_W-1:0] div_op2_o,
    output logic              div_cancel_o,
    input  logic [RES_W-1:0]  div_result_i,
    input  logic              div_ready_i,
    output logic              stall_req_o,
    output logic              hilo_we_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              err_o
);

    localparam int unsigned CNT_W = $clog2(DIV_TIMEOUT + 1);

    div_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_signed;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    logic w_idle;
    logic w_busy;
    logic w_done;
    logic w_accept;
    logic w_timeout;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_busy    = (r_state == ST_BUSY);
    assign w_done    = (r_state == ST_DONE);
    assign w_accept  = !rst && w_idle && div_valid_i && !flush_i;
    // Flush and ready both outrank the timeout; rst masks every strobe.
    assign w_timeout = !rst && w_busy && !flush_i && !div_ready_i
                       && (r_cnt == CNT_W'(DIV_TIMEOUT));

    assign stall_req_o  = w_accept || (!rst && w_busy);
    assign div_start_o  = !rst && w_busy && !flush_i && !w_timeout;
    assign div_cancel_o = !rst && w_busy && (flush_i || w_timeout);
    assign err_o        = w_timeout;
    assign hilo_we_o    = !rst && w_done && !flush_i;

    assign div_signed_o = r_signed;
    assign div_op1_o    = r_op1;
    assign div_op2_o    = r_op2;
    assign hi_o         = r_hi;
    assign lo_o         = r_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_signed <= 1'b0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_signed <= div_signed_i;
                        r_op1    <= op1_i;
                        r_op2    <= op2_i;
                        r_cnt    <= '0;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (flush_i) begin
                        r_state <= ST_IDLE;
                    end else if (div_ready_i) begin
                        r_hi    <= div_result_i[RES_W-1:DATA_W];
                        r_lo    <= div_result_i[DATA_W-1:0];
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized bench for div_ctrl with a behavioural divider stub and a
// cycle-level reference model compared on every falling edge.
module tb_div_ctrl;

    localparam int unsigned TMO = 48;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_valid_i = 1'b0;
    logic        div_signed_i = 1'b0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic        flush_i = 1'b0;
    logic        div_start_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic        div_cancel_o;
    logic [63:0] div_result_i = '0;
    logic        div_ready_i = 1'b0;
    logic        stall_req_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        err_o;

    div_ctrl #(.DIV_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_valid_i  (div_valid_i),
        .div_signed_i (div_signed_i),
        .op1_i        (op1_i),
        .op2_i        (op2_i),
        .flush_i      (flush_i),
        .div_start_o  (div_start_o),
        .div_signed_o (div_signed_o),
        .div_op1_o    (div_op1_o),
        .div_op2_o    (div_op2_o),
        .div_cancel_o (div_cancel_o),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .stall_req_o  (stall_req_o),
        .hilo_we_o    (hilo_we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;

    always @(posedge clk) cyc++;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // MIPS-style divide: truncating quotient, remainder takes dividend sign, /0 gives 0.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
        end
        return {r[31:0], q[31:0]};
    endfunction

    // Divider stub: ready after s_lat consecutive start cycles, held while start stays high.
    int unsigned s_cnt = 0;
    int unsigned s_lat = 0;   // 0 means the divider never answers

    always @(negedge clk) s_cnt = div_start_o ? s_cnt + 1 : 0;

    always @(posedge clk) begin
        #2;
        if (s_lat != 0 && s_cnt >= s_lat) begin
            div_ready_i  = 1'b1;
            div_result_i = ref_div(div_signed_o, div_op1_o, div_op2_o);
        end else begin
            div_ready_i  = 1'b0;
            div_result_i = {$urandom, $urandom};
        end
    end

    // Reference model: outstanding-request bookkeeping, not the RTL state machine.
    bit          m_busy = 0;
    bit          m_done = 0;
    int unsigned m_wait = 0;
    logic        m_sgn  = 1'b0;
    logic [31:0] m_a = '0, m_b = '0, m_hi = '0, m_lo = '0;

    int unsigned n_we = 0, n_cancel = 0, n_err = 0;
    int unsigned we_cyc = 0, err_cyc = 0;
    logic [31:0] last_hi = '0, last_lo = '0;

    always @(negedge clk) begin
        logic e_stall, e_start, e_cancel, e_we, e_err;
        check("hi_o", hi_o, m_hi);
        check("lo_o", lo_o, m_lo);
        check("div_signed_o", div_signed_o, m_sgn);
        check("div_op1_o", div_op1_o, m_a);
        check("div_op2_o", div_op2_o, m_b);
        e_stall = 0; e_start = 0; e_cancel = 0; e_we = 0; e_err = 0;
        if (rst) begin
            m_busy = 0; m_done = 0; m_sgn = 0;
            m_a = '0; m_b = '0; m_hi = '0; m_lo = '0;
        end else if (m_done) begin
            e_we   = !flush_i;
            m_done = 0;
        end else if (m_busy) begin
            e_stall = 1;
            if (flush_i) begin
                e_cancel = 1;
                m_busy   = 0;
            end else if (div_ready_i) begin
                e_start = 1;
                {m_hi, m_lo} = ref_div(m_sgn, m_a, m_b);
                m_busy = 0;
                m_done = 1;
            end else if (m_wait == TMO) begin
                e_cancel = 1;
                e_err    = 1;
                m_busy   = 0;
            end else begin
                e_start = 1;
                m_wait++;
            end
        end else if (div_valid_i && !flush_i) begin
            e_stall = 1;
            m_busy  = 1;
            m_wait  = 0;
            m_sgn   = div_signed_i;
            m_a     = op1_i;
            m_b     = op2_i;
        end
        check("stall_req_o", stall_req_o, e_stall);
        check("div_start_o", div_start_o, e_start);
        check("div_cancel_o", div_cancel_o, e_cancel);
        check("hilo_we_o", hilo_we_o, e_we);
        check("err_o", err_o, e_err);
        if (hilo_we_o) begin n_we++; we_cyc = cyc; last_hi = hi_o; last_lo = lo_o; end
        if (div_cancel_o) n_cancel++;
        if (err_o) begin n_err++; err_cyc = cyc; end
    end

    int unsigned issue_cyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide in IDLE; flush_at/rst_at are BUSY-relative cycle indices (-1 = none).
    task automatic run_req(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int unsigned lat, input int flush_at, input int rst_at);
        int k;
        bit fin;
        s_lat = lat;
        div_valid_i = 1'b1; div_signed_i = sgn; op1_i = a; op2_i = b;
        flush_i = 1'b0; rst = 1'b0;
        issue_cyc = cyc;
        tick();
        div_valid_i = 1'b0; div_signed_i = 1'($urandom); op1_i = $urandom; op2_i = $urandom;
        k = 0;
        fin = 0;
        while (!fin) begin
            if (!m_busy && !m_done && k > flush_at && k > rst_at) begin
                fin = 1;
            end else if (k > 150) begin
                total++;
                bad++;
                $display("FAIL req_timeout: still busy after %0d cycles, required idle", k);
                fin = 1;
            end else begin
                flush_i = (k == flush_at);
                rst     = (k == rst_at);
                tick();
                k++;
            end
        end
        flush_i = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        int unsigned w0, c0, e0, first_we;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        w0 = n_we;
        run_req(1'b0, 32'd100, 32'd7, 10, -1, -1);
        check("divu_we_count", n_we - w0, 1);
        check("divu_lo", last_lo, 32'd14);
        check("divu_hi", last_hi, 32'd2);
        check("divu_latency", we_cyc - issue_cyc, 12);

        run_req(1'b1, -32'sd100, 32'd7, 20, -1, -1);
        check("div_lo", last_lo, 32'hFFFF_FFF2);
        check("div_hi", last_hi, 32'hFFFF_FFFE);

        w0 = n_we; e0 = n_err;
        run_req(1'b0, 32'd5, 32'd0, 2, -1, -1);
        check("div0_we_count", n_we - w0, 1);
        check("div0_lo", last_lo, 32'd0);
        check("div0_hi", last_hi, 32'd0);
        check("div0_err", n_err - e0, 0);

        w0 = n_we; c0 = n_cancel;
        run_req(1'b0, 32'd1000, 32'd3, 20, 10, -1);
        check("flush_cancel_count", n_cancel - c0, 1);
        check("flush_we_count", n_we - w0, 0);
        run_req(1'b0, 32'd100, 32'd7, 5, -1, -1);
        check("after_flush_lo", last_lo, 32'd14);
        check("after_flush_hi", last_hi, 32'd2);

        w0 = n_we; c0 = n_cancel; e0 = n_err;
        run_req(1'b0, 32'd77, 32'd5, 0, -1, -1);
        check("tmo_cancel_count", n_cancel - c0, 1);
        check("tmo_err_count", n_err - e0, 1);
        check("tmo_cycle", err_cyc - issue_cyc, TMO + 1);
        check("tmo_we_count", n_we - w0, 0);

        w0 = n_we; e0 = n_err;
        run_req(1'b0, 32'd77, 32'd5, TMO, -1, -1);
        check("ready_at_tmo_we", n_we - w0, 1);
        check("ready_at_tmo_err", n_err - e0, 0);

        run_req(1'b0, 32'd100, 32'd7, 6, -1, -1);
        first_we = we_cyc;
        check("b2b_first_lo", last_lo, 32'd14);
        run_req(1'b0, 32'd81, 32'd9, 6, -1, -1);
        check("b2b_gap", issue_cyc - first_we, 1);
        check("b2b_lo", last_lo, 32'd9);
        check("b2b_hi", last_hi, 32'd0);

        w0 = n_we; c0 = n_cancel;
        run_req(1'b0, 32'd50, 32'd4, 8, 8, -1);
        check("flush_vs_ready_we", n_we - w0, 0);
        check("flush_vs_ready_cancel", n_cancel - c0, 1);

        w0 = n_we; c0 = n_cancel;
        run_req(1'b0, 32'd50, 32'd4, 8, 9, -1);
        check("flush_done_we", n_we - w0, 0);
        check("flush_done_cancel", n_cancel - c0, 0);

        w0 = n_we; e0 = n_err;
        run_req(1'b1, 32'd123, 32'd4, 20, -1, 5);
        check("rst_busy_we", n_we - w0, 0);
        check("rst_busy_err", n_err - e0, 0);

        div_valid_i = 1'b1; flush_i = 1'b1;
        tick();
        div_valid_i = 1'b0; flush_i = 1'b0;
        tick();

        for (int i = 0; i < 60; i++) begin
            logic        sgn;
            logic [31:0] a, b;
            int unsigned lat;
            int          fa, ra;
            sgn = 1'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 15));
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            lat = (b == 32'd0) ? 2 : $urandom_range(1, 33);
            fa  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, lat + 1)) : -1;
            ra  = (fa < 0 && $urandom_range(0, 11) == 0) ? int'($urandom_range(0, lat)) : -1;
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    div_valid_i = 1'($urandom);
                    flush_i     = div_valid_i;
                    tick();
                end
                div_valid_i = 1'b0;
                flush_i     = 1'b0;
            end
            run_req(sgn, a, b, lat, fa, ra);
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: DIV_TIMEOUT, default 48, max BUSY cycles before forced abort.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 div_valid_i  in  1  EX stage holds a DIV/DIVU this cycle.
REQ-005 div_signed_i  in  1  1 = DIV (signed), 0 = DIVU.
REQ-006 op1_i / op2_i  in  32 each  dividend / divisor.
REQ-007 flush_i  in  1  pipeline flush; kills the in-flight divide.
REQ-008 div_start_o  out  1  start request to divider.
REQ-009 div_signed_o  out  1  latched signedness to divider.
REQ-010 div_op1_o / div_op2_o  out  32 each  latched operands to divider.
REQ-011 div_cancel_o  out  1  abort request to divider.
REQ-012 div_result_i  in  64  divider result {remainder, quotient}.
REQ-013 div_ready_i  in  1  divider result valid.
REQ-014 stall_req_o  out  1  freeze pipeline front end.
REQ-015 hilo_we_o  out  1  one-cycle HI/LO write strobe.
REQ-016 hi_o / lo_o  out  32 each  remainder / quotient.
REQ-017 err_o  out  1  one-cycle timeout pulse.

Function
REQ-018 FSM states IDLE, BUSY, DONE; divider protocol: start held high until ready, ready held while start high, divider idles when start drops, cancel aborts a running divide.
REQ-019 IDLE: on div_valid_i=1 and flush_i=0, latch signedness and operands, clear timeout counter, go BUSY; otherwise stay IDLE.
REQ-020 stall_req_o = (IDLE and div_valid_i and not flush_i) or BUSY, combinational, so the stall takes effect in the accept cycle.
REQ-021 BUSY: div_start_o=1, operand outputs stable, counter increments each cycle.
REQ-022 BUSY and flush_i=1: div_cancel_o=1 and div_start_o=0 for that cycle, go IDLE, no HI/LO write; flush takes priority over div_ready_i in the same cycle.
REQ-023 BUSY and div_ready_i=1 (no flush): capture hi=div_result_i[63:32], lo=div_result_i[31:0], go DONE.
REQ-024 BUSY and counter reaches DIV_TIMEOUT with no ready: div_cancel_o=1, err_o=1 for one cycle, go IDLE, no write; ready in the same cycle wins over timeout.
REQ-025 DONE: div_start_o=0, stall_req_o=0, hilo_we_o=1 for exactly one cycle unless flush_i=1 (then suppressed); always return to IDLE next cycle.
REQ-026 div_start_o and div_cancel_o never both 1; outside BUSY both are 0.
REQ-027 A new request is not accepted in DONE; earliest re-accept is the IDLE cycle following DONE or abort.
REQ-028 Divide-by-zero handled by divider (result 0, ready after ~2 cycles); controller writes hi=0, lo=0, err_o=0.
REQ-029 Nominal latency accept -> hilo_we_o is 36 cycles or fewer for nonzero divisor.

Reset
REQ-030 rst: state IDLE; counter 0; all outputs 0 including hi_o, lo_o and the latched operands.
REQ-031 rst mid-BUSY: return to IDLE next cycle with start 0; no write, no err_o pulse.

Structure
REQ-032 Shared package holds the state encoding, DIV_TIMEOUT default, and the 32/64 data-width constants.
REQ-033 No sub-module; the divider is instantiated beside div_ctrl at EX-stage level, not inside it.

Verification
REQ-034 DIVU 100/7 -> hilo_we_o pulse, lo_o=14, hi_o=2, stall_req_o high from accept to DONE.
REQ-035 DIV -100/7 -> lo_o=0xFFFFFFF2, hi_o=0xFFFFFFFE.
REQ-036 DIVU 5/0 -> hi_o=0, lo_o=0, hilo_we_o pulse, err_o=0.
REQ-037 flush_i at BUSY cycle 10 -> one div_cancel_o pulse, no hilo_we_o; next request 100/7 completes correctly.
REQ-038 Stub divider never ready -> div_cancel_o and err_o pulse at BUSY cycle 48, FSM in IDLE.
REQ-039 Back-to-back 100/7 then 81/9 -> two writes (lo 14, hi 2), then (lo 9, hi 0); start low for at least one cycle between the two divides.
